// File: rtl/node_split_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : node_split_commit_pkg
// Description : Shared definitions for the node-split commit block. Holds the
//               default gene/attribute widths, the identifier and attribute
//               constants, the field index map of a gene, the error codes and
//               the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package node_split_commit_pkg;

    // Default geometry: eight ATTR_SZ-wide fields per gene
    localparam int C_GENE_SZ = 64;
    localparam int C_ATTR_SZ = 8;

    // Identifier field values and the default attribute value
    localparam logic [7:0] C_ID_NODE      = 8'h00;
    localparam logic [7:0] C_ID_CONN      = 8'h80;
    localparam logic [7:0] C_ATTR_DEFAULT = 8'h01;

    // Field index, counted from the least significant field upwards
    localparam int C_FLD_F0     = 0;
    localparam int C_FLD_F1     = 1;
    localparam int C_FLD_ENABLE = 2;   // f2
    localparam int C_FLD_WEIGHT = 3;   // f3
    localparam int C_FLD_DEST   = 4;   // f4
    localparam int C_FLD_SRC    = 5;   // f5
    localparam int C_FLD_IDENT  = 6;
    localparam int C_FLD_GENOME = 7;

    // Rejection codes reported on err_code
    localparam logic [1:0] C_ERR_NONE     = 2'b00;
    localparam logic [1:0] C_ERR_NOT_CONN = 2'b01;
    localparam logic [1:0] C_ERR_NID_OVF  = 2'b10;
    localparam logic [1:0] C_ERR_MEM_FULL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISABLE  = 3'd1,
        ST_WR_NODE  = 3'd2,
        ST_WR_CONN1 = 3'd3,
        ST_WR_CONN2 = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/node_split_gene_former.sv
`default_nettype none
// ============================================================================
// Module      : node_split_gene_former
// Description : Combinational former of the four genes written by a node
//               split. For the selected write state it produces the target
//               address and the gene to store there.
// Ports       : sel       - write state whose gene is to be formed
//               gene      - original connection gene being split
//               gene_addr - memory address of the original gene
//               tail      - first free gene address
//               nid       - identifier of the new node
//               wr_addr   - formed write address
//               wr_data   - formed write data
// Revision    : 1.0 - initial release
// ============================================================================
module node_split_gene_former
    import node_split_commit_pkg::*;
#(
    parameter int GENE_SZ = C_GENE_SZ,
    parameter int ATTR_SZ = C_ATTR_SZ,
    parameter int ADDR_W  = 8
)(
    input  state_t              sel,
    input  logic [GENE_SZ-1:0]  gene,
    input  logic [ADDR_W-1:0]   gene_addr,
    input  logic [ADDR_W-1:0]   tail,
    input  logic [ATTR_SZ-1:0]  nid,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [GENE_SZ-1:0]  wr_data
);

    localparam logic [ATTR_SZ-1:0] C_A_NODE = ATTR_SZ'(C_ID_NODE);
    localparam logic [ATTR_SZ-1:0] C_A_CONN = ATTR_SZ'(C_ID_CONN);
    localparam logic [ATTR_SZ-1:0] C_A_DEF  = ATTR_SZ'(C_ATTR_DEFAULT);
    localparam logic [ATTR_SZ-1:0] C_A_ZERO = '0;

    logic [ATTR_SZ-1:0] w_genome;
    logic [ATTR_SZ-1:0] w_src;
    logic [ATTR_SZ-1:0] w_dest;
    logic [ATTR_SZ-1:0] w_weight;
    logic [ATTR_SZ-1:0] w_f1;
    logic [ATTR_SZ-1:0] w_f0;
    logic [GENE_SZ-1:0] w_disabled;

    assign w_genome = gene[C_FLD_GENOME*ATTR_SZ +: ATTR_SZ];
    assign w_src    = gene[C_FLD_SRC*ATTR_SZ    +: ATTR_SZ];
    assign w_dest   = gene[C_FLD_DEST*ATTR_SZ   +: ATTR_SZ];
    assign w_weight = gene[C_FLD_WEIGHT*ATTR_SZ +: ATTR_SZ];
    assign w_f1     = gene[C_FLD_F1*ATTR_SZ     +: ATTR_SZ];
    assign w_f0     = gene[C_FLD_F0*ATTR_SZ     +: ATTR_SZ];

    // Original gene with only its enable field cleared
    always_comb begin
        w_disabled = gene;
        w_disabled[C_FLD_ENABLE*ATTR_SZ +: ATTR_SZ] = C_A_ZERO;
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (sel)
            ST_DISABLE: begin
                wr_addr = gene_addr;
                wr_data = w_disabled;
            end
            ST_WR_NODE: begin
                wr_addr = tail;
                wr_data = GENE_SZ'({w_genome, C_A_NODE, nid, C_A_ZERO,
                                    C_A_DEF, C_A_DEF, C_A_DEF, C_A_DEF});
            end
            ST_WR_CONN1: begin
                // src -> new node, weight 1, enabled
                wr_addr = tail + ADDR_W'(1);
                wr_data = GENE_SZ'({w_genome, C_A_CONN, w_src, nid,
                                    C_A_DEF, C_A_DEF, C_A_ZERO, C_A_ZERO});
            end
            ST_WR_CONN2: begin
                // new node -> dest, inherits the original weight and f1/f0
                wr_addr = tail + ADDR_W'(2);
                wr_data = GENE_SZ'({w_genome, C_A_CONN, nid, w_dest,
                                    w_weight, C_A_DEF, w_f1, w_f0});
            end
            default: begin
                wr_addr = '0;
                wr_data = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/node_split_commit.sv
`default_nettype none
// ============================================================================
// Module      : node_split_commit
// Description : Splits a connection gene by inserting a new node. The original
//               connection is disabled in place, then a node gene and two new
//               connection genes are appended at the tail of gene memory.
//               Checks are made at acceptance; a rejected gene leaves all
//               state untouched and raises err for one cycle.
// Ports       : clk, rst_n               - clock, synchronous active-low reset
//               init_load/_max_node_id/_tail - load node id and tail (IDLE only)
//               in_valid/in_ready/in_gene/in_addr - gene offer handshake
//               wr_en/wr_ready/wr_addr/wr_data    - gene memory write port
//               done, err, err_code      - completion / rejection pulses
//               max_node_id, tail        - current node id and free address
// Revision    : 1.0 - initial release
// ============================================================================
module node_split_commit
    import node_split_commit_pkg::*;
#(
    parameter int GENE_SZ = C_GENE_SZ,
    parameter int ATTR_SZ = C_ATTR_SZ,
    parameter int ADDR_W  = 8
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_load,
    input  logic [ATTR_SZ-1:0]  init_max_node_id,
    input  logic [ADDR_W-1:0]   init_tail,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [GENE_SZ-1:0]  in_gene,
    input  logic [ADDR_W-1:0]   in_addr,
    output logic                wr_en,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [GENE_SZ-1:0]  wr_data,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ATTR_SZ-1:0]  max_node_id,
    output logic [ADDR_W-1:0]   tail
);

    // Highest tail that still leaves room for three appended genes
    localparam logic [ADDR_W-1:0] C_TAIL_LIM = {ADDR_W{1'b1}} - ADDR_W'(2);
    localparam int                C_IDENT_MSB = C_FLD_IDENT*ATTR_SZ + ATTR_SZ - 1;

    state_t             r_state;
    logic [GENE_SZ-1:0] r_gene;
    logic [ADDR_W-1:0]  r_gene_addr;
    logic [ATTR_SZ-1:0] r_nid;
    logic [ATTR_SZ-1:0] r_max_node_id;
    logic [ADDR_W-1:0]  r_tail;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [GENE_SZ-1:0] r_wr_data;
    logic               r_done;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic               w_in_ready;
    logic [ATTR_SZ-1:0] w_nid_next;
    logic [1:0]         w_chk_code;
    state_t             w_form_sel;
    logic [GENE_SZ-1:0] w_form_gene;
    logic [ADDR_W-1:0]  w_form_gene_addr;
    logic [ATTR_SZ-1:0] w_form_nid;
    logic [ADDR_W-1:0]  w_form_addr;
    logic [GENE_SZ-1:0] w_form_data;

    assign w_in_ready = (r_state == ST_IDLE) && !init_load;
    assign w_nid_next = r_max_node_id + ATTR_SZ'(1);

    // Acceptance checks in priority order, evaluated on the offered gene
    always_comb begin
        w_chk_code = C_ERR_NONE;
        if (!in_gene[C_IDENT_MSB]) begin
            w_chk_code = C_ERR_NOT_CONN;
        end else if (&r_max_node_id) begin
            w_chk_code = C_ERR_NID_OVF;
        end else if (r_tail > C_TAIL_LIM) begin
            w_chk_code = C_ERR_MEM_FULL;
        end
    end

    // The former is asked for the gene of the state being entered next so
    // that wr_addr/wr_data are registered together with the state. In IDLE
    // the gene is not yet captured, so the live inputs are used.
    always_comb begin
        w_form_sel       = ST_IDLE;
        w_form_gene      = r_gene;
        w_form_gene_addr = r_gene_addr;
        w_form_nid       = r_nid;
        case (r_state)
            ST_IDLE: begin
                w_form_sel       = ST_DISABLE;
                w_form_gene      = in_gene;
                w_form_gene_addr = in_addr;
                w_form_nid       = w_nid_next;
            end
            ST_DISABLE:  w_form_sel = ST_WR_NODE;
            ST_WR_NODE:  w_form_sel = ST_WR_CONN1;
            ST_WR_CONN1: w_form_sel = ST_WR_CONN2;
            default:     w_form_sel = ST_IDLE;
        endcase
    end

    node_split_gene_former #(
        .GENE_SZ (GENE_SZ),
        .ATTR_SZ (ATTR_SZ),
        .ADDR_W  (ADDR_W)
    ) u_former (
        .sel       (w_form_sel),
        .gene      (w_form_gene),
        .gene_addr (w_form_gene_addr),
        .tail      (r_tail),
        .nid       (w_form_nid),
        .wr_addr   (w_form_addr),
        .wr_data   (w_form_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_gene        <= '0;
            r_gene_addr   <= '0;
            r_nid         <= '0;
            r_max_node_id <= '0;
            r_tail        <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= C_ERR_NONE;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (init_load) begin
                        r_max_node_id <= init_max_node_id;
                        r_tail        <= init_tail;
                    end else if (in_valid) begin
                        r_gene      <= in_gene;
                        r_gene_addr <= in_addr;
                        r_nid       <= w_nid_next;
                        if (w_chk_code != C_ERR_NONE) begin
                            r_err      <= 1'b1;
                            r_err_code <= w_chk_code;
                        end else begin
                            r_state   <= ST_DISABLE;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_form_addr;
                            r_wr_data <= w_form_data;
                        end
                    end
                end
                ST_DISABLE, ST_WR_NODE, ST_WR_CONN1: begin
                    // Address/data only move once the current write is taken
                    if (wr_ready) begin
                        r_state   <= w_form_sel;
                        r_wr_addr <= w_form_addr;
                        r_wr_data <= w_form_data;
                    end
                end
                ST_WR_CONN2: begin
                    if (wr_ready) begin
                        r_state <= ST_DONE;
                        r_wr_en <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_max_node_id <= r_nid;
                    r_tail        <= r_tail + ADDR_W'(3);
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign max_node_id = r_max_node_id;
    assign tail        = r_tail;

endmodule
`default_nettype wire

// File: tb/tb_node_split_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_node_split_commit
// Description : Self-checking bench for node_split_commit. A gene-level
//               reference model predicts the four writes, the rejection code
//               and the node/tail registers for every offered gene.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_split_commit;

    localparam int GENE_SZ = 64;
    localparam int ATTR_SZ = 8;
    localparam int ADDR_W  = 8;
    localparam logic [63:0] C_G_REF = 64'h0180_0203_0501_0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               init_load;
    logic [ATTR_SZ-1:0] init_max_node_id;
    logic [ADDR_W-1:0]  init_tail;
    logic               in_valid;
    logic               in_ready;
    logic [GENE_SZ-1:0] in_gene;
    logic [ADDR_W-1:0]  in_addr;
    logic               wr_en;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [GENE_SZ-1:0] wr_data;
    logic               done;
    logic               err;
    logic [1:0]         err_code;
    logic [ATTR_SZ-1:0] max_node_id;
    logic [ADDR_W-1:0]  tail;

    node_split_commit #(
        .GENE_SZ (GENE_SZ),
        .ATTR_SZ (ATTR_SZ),
        .ADDR_W  (ADDR_W)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init_load        (init_load),
        .init_max_node_id (init_max_node_id),
        .init_tail        (init_tail),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_gene          (in_gene),
        .in_addr          (in_addr),
        .wr_en            (wr_en),
        .wr_ready         (wr_ready),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .done             (done),
        .err              (err),
        .err_code         (err_code),
        .max_node_id      (max_node_id),
        .tail             (tail)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  m_max  = 8'h00;
    logic [7:0]  m_tail = 8'h00;
    int          exp_code;
    logic [7:0]  exp_addr [4];
    logic [63:0] exp_data [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Gene-level prediction from the current model registers
    task automatic model_split(input logic [63:0] g, input logic [7:0] a);
        logic [7:0] f [8];
        logic [7:0] nid;
        for (int i = 0; i < 8; i++) f[i] = g[8*i +: 8];
        nid = m_max + 8'd1;
        if (f[6][7] == 1'b0)      exp_code = 1;
        else if (m_max == 8'hFF)  exp_code = 2;
        else if (m_tail > 8'd253) exp_code = 3;
        else                      exp_code = 0;
        exp_addr[0] = a;
        exp_data[0] = {f[7], f[6], f[5], f[4], f[3], 8'h00, f[1], f[0]};
        exp_addr[1] = m_tail;
        exp_data[1] = {f[7], 8'h00, nid, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
        exp_addr[2] = m_tail + 8'd1;
        exp_data[2] = {f[7], 8'h80, f[5], nid, 8'h01, 8'h01, 8'h00, 8'h00};
        exp_addr[3] = m_tail + 8'd2;
        exp_data[3] = {f[7], 8'h80, nid, f[4], f[3], 8'h01, f[1], f[0]};
    endtask

    task automatic do_init(input logic [7:0] mx, input logic [7:0] tl);
        @(negedge clk);
        init_load = 1'b1; init_max_node_id = mx; init_tail = tl;
        @(negedge clk);
        init_load = 1'b0;
        m_max = mx; m_tail = tl;
        check_eq("init_max", 64'(max_node_id), 64'(m_max));
        check_eq("init_tail", 64'(tail), 64'(m_tail));
    endtask

    // mode 0: wr_ready always 1; mode 1: two stall cycles per write; mode 2: random
    task automatic run_split(input logic [63:0] g, input logic [7:0] a, input int mode, input bit pre);
        int   k_done = -1;
        int   k_err  = -1;
        int   n_got  = 0;
        int   n_stall = 0;
        int   scnt   = 0;
        logic rdy;
        model_split(g, a);
        if (!pre) @(negedge clk);
        init_load = 1'b0; in_valid = 1'b1; in_gene = g; in_addr = a;
        #1;
        check_eq("in_ready_offer", 64'(in_ready), 64'(1));
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid = 1'b0;
                in_gene  = {$urandom, $urandom};
                in_addr  = 8'($urandom);
            end
            if (done) begin
                k_done = k; wr_ready = 1'b0; init_load = 1'b0;
                break;
            end
            if (err) begin
                k_err = k;
                check_eq("err_code", 64'(err_code), 64'(exp_code));
                break;
            end
            if (wr_en) begin
                if (n_got < 4) begin
                    check_eq("wr_addr", 64'(wr_addr), 64'(exp_addr[n_got]));
                    check_eq("wr_data", wr_data, exp_data[n_got]);
                end else begin
                    check_eq("write_index", 64'(n_got), 64'(3));
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: begin
                        if (scnt < 2) begin rdy = 1'b0; scnt++; end
                        else begin rdy = 1'b1; scnt = 0; end
                    end
                    default: rdy = (($urandom % 3) != 0);
                endcase
                if (rdy) n_got++; else n_stall++;
                wr_ready = rdy;
                // load requests outside IDLE must be ignored
                init_load        = 1'($urandom);
                init_max_node_id = 8'($urandom);
                init_tail        = 8'($urandom);
            end else begin
                wr_ready  = 1'($urandom);
                init_load = 1'b0;
            end
        end
        init_load = 1'b0;
        if (exp_code == 0) begin
            check_eq("done_latency", 64'(k_done), 64'(5 + n_stall));
            check_eq("write_count", 64'(n_got), 64'(4));
            @(negedge clk);
            m_max  = m_max + 8'd1;
            m_tail = m_tail + 8'd3;
            check_eq("in_ready_after_done", 64'(in_ready), 64'(1));
            check_eq("max_after_done", 64'(max_node_id), 64'(m_max));
            check_eq("tail_after_done", 64'(tail), 64'(m_tail));
        end else begin
            check_eq("err_latency", 64'(k_err), 64'(1));
            check_eq("write_count_err", 64'(n_got), 64'(0));
            check_eq("max_after_err", 64'(max_node_id), 64'(m_max));
            check_eq("tail_after_err", 64'(tail), 64'(m_tail));
        end
    endtask

    initial begin
        logic [63:0] g;
        logic [7:0]  mx, tl;
        rst_n = 1'b0; init_load = 1'b0; init_max_node_id = '0; init_tail = '0;
        in_valid = 1'b0; in_gene = '0; in_addr = '0; wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_wr_en", 64'(wr_en), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_err", 64'(err), 64'(0));
        check_eq("rst_err_code", 64'(err_code), 64'(0));
        check_eq("rst_max", 64'(max_node_id), 64'(0));
        check_eq("rst_tail", 64'(tail), 64'(0));
        check_eq("rst_wr_addr", 64'(wr_addr), 64'(0));
        check_eq("rst_wr_data", wr_data, 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));

        // Load and offer together: load wins, gene taken on the next cycle
        @(negedge clk);
        init_load = 1'b1; init_max_node_id = 8'h05; init_tail = 8'h10;
        in_valid = 1'b1; in_gene = C_G_REF; in_addr = 8'h04;
        #1;
        check_eq("in_ready_during_load", 64'(in_ready), 64'(0));
        @(negedge clk);
        init_load = 1'b0;
        check_eq("no_accept_on_load", 64'(wr_en), 64'(0));
        m_max = 8'h05; m_tail = 8'h10;
        check_eq("load_max", 64'(max_node_id), 64'(m_max));
        check_eq("load_tail", 64'(tail), 64'(m_tail));
        run_split(C_G_REF, 8'h04, 0, 1'b1);

        // Same split with two stall cycles on every write
        do_init(8'h05, 8'h10);
        run_split(C_G_REF, 8'h04, 1, 1'b0);

        // Node gene is rejected
        run_split(64'h0100_0203_0501_0000, 8'h05, 0, 1'b0);

        // Node id overflow, memory full, and the last tail that still fits
        do_init(8'hFF, 8'h10);
        run_split(C_G_REF, 8'h04, 0, 1'b0);
        do_init(8'h05, 8'hFE);
        run_split(C_G_REF, 8'h04, 0, 1'b0);
        do_init(8'h07, 8'hFD);
        run_split(C_G_REF, 8'h09, 2, 1'b0);

        // Reset in the middle of the sequence
        do_init(8'h20, 8'h30);
        @(negedge clk);
        in_valid = 1'b1; in_gene = C_G_REF; in_addr = 8'h02; wr_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("conn1_wr_en", 64'(wr_en), 64'(1));
        check_eq("conn1_wr_addr", 64'(wr_addr), 64'(8'h31));
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_wr_en", 64'(wr_en), 64'(0));
        check_eq("midrst_max", 64'(max_node_id), 64'(0));
        check_eq("midrst_tail", 64'(tail), 64'(0));
        rst_n = 1'b1; wr_ready = 1'b0;
        m_max = 8'h00; m_tail = 8'h00;
        @(negedge clk);
        check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
        check_eq("midrst_done", 64'(done), 64'(0));

        // Randomised traffic
        for (int it = 0; it < 30; it++) begin
            if (($urandom % 3) == 0) begin
                case ($urandom % 4)
                    0:       mx = 8'hFF;
                    1:       mx = 8'hFE;
                    default: mx = 8'($urandom);
                endcase
                case ($urandom % 4)
                    0:       tl = 8'hFD;
                    1:       tl = 8'hFE;
                    default: tl = 8'($urandom);
                endcase
                do_init(mx, tl);
            end
            g = {$urandom, $urandom};
            g[55] = (($urandom % 5) != 0);
            run_split(g, 8'($urandom), int'($urandom % 3), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/node_split_commit.md
NODE_SPLIT_COMMIT -- requirements
Module: node_split_commit

Interface
REQ-001 SHALL have parameter GENE_SZ, default 64, gene width in bits.
REQ-002 SHALL have parameter ATTR_SZ, default 8, attribute field width.
REQ-003 SHALL have parameter ADDR_W, default 8, gene memory address width (depth 2^ADDR_W).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- init_load  in  1  load the node and tail registers.
- init_max_node_id  in  ATTR_SZ  max node id value for init_load.
- init_tail  in  ADDR_W  first free gene address for init_load.
- in_valid  in  1  connection gene offered for splitting.
- in_ready  out  1  block accepts a connection gene.
- in_gene  in  GENE_SZ  connection gene to split.
- in_addr  in  ADDR_W  memory address of in_gene.
- wr_en  out  1  gene memory write request.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  GENE_SZ  write data.
- done  out  1  one-cycle pulse, split committed.
- err  out  1  one-cycle pulse, split rejected.
- err_code  out  2  01 not a connection gene, 10 node id overflow, 11 memory full; valid with err.
- max_node_id  out  ATTR_SZ  current max node id.
- tail  out  ADDR_W  current first free gene address.

Function
REQ-005 Gene layout, MSB first, ATTR_SZ fields: genome_id, identifier (0x00 node, 0x80 conn), f5, f4, f3, f2, f1, f0; for connections f5=src, f4=dest, f3=weight, f2=enable.
REQ-006 in_ready SHALL be 1 only in IDLE with init_load=0; a transfer occurs when in_valid and in_ready are both 1.
REQ-007 On transfer the block SHALL register in_gene and in_addr and compute nid = max_node_id+1.
REQ-008 Checks SHALL run in priority order: identifier MSB=0 -> code 01; max_node_id=0xFF -> code 10 (no wrap); tail > 2^ADDR_W-3 -> code 11.
REQ-009 On a failed check, err SHALL pulse in the cycle after the transfer, no write SHALL be issued, registers SHALL be unchanged, and the state SHALL return to IDLE.
REQ-010 FSM states SHALL be IDLE, DISABLE, WR_NODE, WR_CONN1, WR_CONN2, DONE; each WR-type state (DISABLE included) SHALL hold wr_en=1 and advance only on wr_ready=1.
REQ-011 In DISABLE, write in_addr <- original gene with f2 = 0x00.
REQ-012 In WR_NODE, write tail <- {genome_id, 0x00, nid, 0x00, 0x01, 0x01, 0x01, 0x01}.
REQ-013 In WR_CONN1, write tail+1 <- {genome_id, 0x80, src, nid, 0x01, 0x01, 0x00, 0x00}.
REQ-014 In WR_CONN2, write tail+2 <- {genome_id, 0x80, nid, dest, orig weight, 0x01, orig f1, orig f0}.
REQ-015 In DONE, done SHALL pulse, max_node_id <= nid, tail <= tail+3, then the state SHALL return to IDLE.
REQ-016 Minimum latency with wr_ready held 1: transfer at cycle T, writes at T+1..T+4, done at T+5, in_ready high at T+6.
REQ-017 wr_addr and wr_data SHALL be stable while wr_en=1 and wr_ready=0; wr_en SHALL be 0 outside the write states.
REQ-018 init_load SHALL be honoured only in IDLE and takes priority over a simultaneous in_valid; init_load outside IDLE SHALL be ignored.
REQ-019 All address arithmetic SHALL be ADDR_W-bit; overflow is prevented by REQ-008.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-sequence, abandoning any partial writes.
REQ-021 Reset values: wr_en=0, done=0, err=0, err_code=00, max_node_id=0, tail=0, wr_addr=0, wr_data=0; in_ready=1 in the first cycle after reset release.

Structure
REQ-022 A shared package SHALL hold GENE_SZ, ATTR_SZ, identifier constants 0x00/0x80, default attribute 0x01, field index constants, error codes and the FSM state enum.
REQ-023 Gene forming (REQ-011..014) SHALL be a combinational sub-module named node_split_gene_former; node_split_commit holds the FSM and registers.

Verification
REQ-024 init_load max=0x05, tail=0x10; gene 0x0180_0203_0501_0000 at addr 0x04, wr_ready=1 -> writes:
- 0x04 <- 0x0180_0203_0500_0000
- 0x10 <- 0x0100_0600_0101_0101
- 0x11 <- 0x0180_0206_0101_0000
- 0x12 <- 0x0180_0603_0501_0000
- then done; max_node_id=0x06, tail=0x13.
REQ-025 Same case with wr_ready low two cycles per write -> identical writes with stable data; done at T+13.
REQ-026 Node gene (identifier 0x00) offered -> err, code 01, no wr_en, registers unchanged.
REQ-027 max=0xFF -> err code 10; tail=0xFE -> err code 11; no writes.
REQ-028 rst_n=0 during WR_CONN1 -> next cycle IDLE, wr_en=0, max_node_id=0, tail=0.
REQ-029 init_load and in_valid together in IDLE -> load taken, in_ready=0; gene accepted the next cycle.
